// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: memory-side responder for the core data bus.
// It services one transaction at a time from a word-organised RAM.
// A programmable number of wait states sits between acceptance and
// the one-cycle O_ready pulse. All outputs are registered.
module dbus_mem_responder #(
  parameter int unsigned DEPTH       = 131072,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_MASK   = 32'h7fff_ffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  input  logic [3:0]  I_mask,
  output logic [31:0] O_data,
  output logic        O_ready,
  output logic        O_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;

  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;
  logic [3:0]  hold_mask;

  logic [31:0] ram [DEPTH];

  // With zero wait states the response is formed on the accepting edge,
  // so the read side looks at the live bus in IDLE and the held copy otherwise.
  logic        rd_we;
  logic [31:0] rd_addr;
  logic [31:0] rd_wi;
  logic        rd_in_range;
  logic [31:0] hold_wi;
  logic        hold_in_range;

  // Select the transaction the response is built from and decode both addresses.
  always_comb begin
    rd_we         = (state == IDLE) ? I_we : hold_we;
    rd_addr       = (state == IDLE) ? I_addr : hold_addr;
    rd_wi         = (rd_addr & ADDR_MASK) >> 2;
    rd_in_range   = (rd_wi < 32'(DEPTH));
    hold_wi       = (hold_addr & ADDR_MASK) >> 2;
    hold_in_range = (hold_wi < 32'(DEPTH));
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, always leave RESP.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (I_req) begin
          next_cnt   = 4'(WAIT_CYCLES);
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          next_cnt   = 4'd0;
          next_state = RESP;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Capture the bus into the holding registers when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_we   <= 1'b0;
      hold_addr <= 32'h0;
      hold_data <= 32'h0;
      hold_mask <= 4'h0;
    end else if (state == IDLE && I_req) begin
      hold_we   <= I_we;
      hold_addr <= I_addr;
      hold_data <= I_data;
      hold_mask <= I_mask;
    end
  end

  // Registered response: valid exactly while the FSM sits in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      O_ready <= 1'b0;
      O_err   <= 1'b0;
      O_data  <= 32'h0;
    end else if (next_state == RESP) begin
      O_ready <= 1'b1;
      O_err   <= !rd_in_range;
      O_data  <= (!rd_we && rd_in_range) ? ram[rd_wi[AW-1:0]] : 32'h0;
    end else begin
      O_ready <= 1'b0;
      O_err   <= 1'b0;
      O_data  <= 32'h0;
    end
  end

  // Byte-lane write commit on the edge that leaves RESP; RAM is never reset.
  always_ff @(posedge clk) begin
    if (state == RESP && hold_we && hold_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_mask[i]) begin
          ram[hold_wi[AW-1:0]][8*i +: 8] <= hold_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder: directed bench for dbus_mem_responder.
// Four instances with different wait-state settings share the bus inputs;
// each has its own request line, so only the addressed one leaves IDLE.
module tb_dbus_mem_responder;

  logic        clock;
  logic        rstN;
  logic [3:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [3:0]  rdy;
  logic [3:0]  err;
  logic [31:0] dout [4];

  int nChecks;
  int nErrors;

  dbus_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) uW1 (
    .clk(clock), .rst(rstN), .I_req(req[0]), .I_we(we), .I_addr(addr),
    .I_data(wdata), .I_mask(mask), .O_data(dout[0]), .O_ready(rdy[0]), .O_err(err[0]));

  dbus_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) uW0 (
    .clk(clock), .rst(rstN), .I_req(req[1]), .I_we(we), .I_addr(addr),
    .I_data(wdata), .I_mask(mask), .O_data(dout[1]), .O_ready(rdy[1]), .O_err(err[1]));

  dbus_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) uW3 (
    .clk(clock), .rst(rstN), .I_req(req[2]), .I_we(we), .I_addr(addr),
    .I_data(wdata), .I_mask(mask), .O_data(dout[2]), .O_ready(rdy[2]), .O_err(err[2]));

  dbus_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(15)) uW15 (
    .clk(clock), .rst(rstN), .I_req(req[3]), .I_we(we), .I_addr(addr),
    .I_data(wdata), .I_mask(mask), .O_data(dout[3]), .O_ready(rdy[3]), .O_err(err[3]));

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance k. lat counts falling edges after the
  // accepting edge until O_ready is seen (-1 on timeout); after is O_ready
  // one cycle later.
  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               output logic [31:0] rdata, output logic rerr,
                               output int lat, output logic after);
    @(negedge clock);
    we = w; addr = a; wdata = d; mask = m; req[k] = 1'b1;
    @(posedge clock);
    lat = -1; rdata = 32'h0; rerr = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (rdy[k]) begin
        lat = i; rdata = dout[k]; rerr = err[k];
        req[k] = 1'b0;
        break;
      end
    end
    req[k] = 1'b0;
    @(negedge clock);
    after = rdy[k];
  endtask

  logic [31:0] rd;
  logic        re;
  int          lat;
  logic        aft;
  int          pulses;
  int          lastPulse;
  int          seen;
  logic [31:0] expW0 [4];

  initial begin
    nChecks = 0; nErrors = 0;
    rstN = 1'b0; req = 4'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; mask = 4'h0;
    repeat (3) @(negedge clock);
    checkOutput("reset ready", 32'(rdy), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset data", dout[0] | dout[1] | dout[2] | dout[3], 32'h0);
    rstN = 1'b1;

    // Basic read with one wait state.
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'hdead_beef, 4'hf, rd, re, lat, aft);
    checkOutput("w1 write latency", 32'(lat), 32'd2);
    checkOutput("w1 write data", rd, 32'h0);
    applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("w1 read latency", 32'(lat), 32'd2);
    checkOutput("w1 read data", rd, 32'hdead_beef);
    checkOutput("w1 read err", 32'(re), 32'h0);
    checkOutput("w1 read pulse", 32'(aft), 32'h0);

    // Byte-masked write, then an all-zero mask write that must change nothing.
    applyStimulus(0, 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hf, rd, re, lat, aft);
    applyStimulus(0, 1'b1, 32'h8000_0000, 32'haabb_ccdd, 4'b0101, rd, re, lat, aft);
    applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("masked write readback", rd, 32'h11bb_33dd);
    applyStimulus(0, 1'b1, 32'h0000_0000, 32'hffff_ffff, 4'b0000, rd, re, lat, aft);
    checkOutput("zero mask err", 32'(re), 32'h0);
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("zero mask readback", rd, 32'h11bb_33dd);

    // Out-of-range write and read (word index 1024 with DEPTH 1024).
    applyStimulus(0, 1'b1, 32'h8000_1000, 32'h5555_aaaa, 4'hf, rd, re, lat, aft);
    checkOutput("oor write ready", 32'(lat), 32'd2);
    checkOutput("oor write err", 32'(re), 32'h1);
    applyStimulus(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("oor read err", 32'(re), 32'h1);
    checkOutput("oor read data", rd, 32'h0);
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("oor word0 kept", rd, 32'h11bb_33dd);
    checkOutput("in range err", 32'(re), 32'h0);

    // Zero wait states: single latency, then four back-to-back reads.
    expW0[0] = 32'h1000_0000; expW0[1] = 32'h1000_0111;
    expW0[2] = 32'h1000_0222; expW0[3] = 32'h1000_0333;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, 32'(i * 4), expW0[i], 4'hf, rd, re, lat, aft);
      if (i == 0) checkOutput("w0 latency", 32'(lat), 32'd1);
    end
    @(negedge clock);
    we = 1'b0; addr = 32'h0; req[1] = 1'b1;
    pulses = 0; lastPulse = -1;
    for (int c = 1; c <= 20 && pulses < 4; c++) begin
      @(negedge clock);
      if (rdy[1]) begin
        checkOutput($sformatf("b2b data %0d", pulses), dout[1], expW0[pulses]);
        if (pulses > 0) checkOutput($sformatf("b2b gap %0d", pulses), 32'(c - lastPulse), 32'd2);
        lastPulse = c;
        pulses++;
        addr = 32'(pulses * 4);
        if (pulses == 4) req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    checkOutput("b2b pulse count", 32'(pulses), 32'd4);
    @(negedge clock);

    // Three wait states: inputs change and req drops while waiting.
    applyStimulus(2, 1'b1, 32'h0000_0024, 32'h9999_9999, 4'hf, rd, re, lat, aft);
    @(negedge clock);
    we = 1'b1; addr = 32'h0000_0020; wdata = 32'hcafe_babe; mask = 4'hf; req[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    addr = 32'h0000_0024; wdata = 32'h1234_5678; we = 1'b0; mask = 4'h0; req[2] = 1'b0;
    seen = -1;
    for (int i = 2; i <= 20; i++) begin
      if (rdy[2]) begin seen = i - 1; break; end
      @(negedge clock);
    end
    if (seen < 0 && rdy[2]) seen = 20;
    checkOutput("w3 latency", 32'(seen), 32'd4);
    @(negedge clock);
    applyStimulus(2, 1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("w3 captured write", rd, 32'hcafe_babe);
    applyStimulus(2, 1'b0, 32'h0000_0024, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("w3 other word", rd, 32'h9999_9999);

    // Reset during WAIT discards the pending write.
    @(negedge clock);
    we = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_1111; mask = 4'hf; req[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req[2] = 1'b0; rstN = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rdy[2] || err[2] || dout[2] != 32'h0) seen++;
    end
    checkOutput("reset mid outputs", 32'(seen), 32'd0);
    rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rdy[2]) seen++;
    end
    checkOutput("reset mid no ready", 32'(seen), 32'd0);
    applyStimulus(2, 1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("reset mid word kept", rd, 32'hcafe_babe);

    // Fifteen wait states: maximum counter value.
    applyStimulus(3, 1'b1, 32'h0000_0008, 32'h0f0f_0f0f, 4'hf, rd, re, lat, aft);
    checkOutput("w15 write latency", 32'(lat), 32'd16);
    applyStimulus(3, 1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, re, lat, aft);
    checkOutput("w15 read latency", 32'(lat), 32'd16);
    checkOutput("w15 read data", rd, 32'h0f0f_0f0f);
    checkOutput("w15 read pulse", 32'(aft), 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
# dbus_mem_responder

Memory-side responder for the core's data bus (req / we / addr / data / mask). It services one transaction at a time from an internal word-organised RAM and inserts a programmable number of wait states. It answers with a one-cycle `O_ready` pulse, plus `O_err` for out-of-range addresses. It replaces the zero-latency behavioural memory on the dbus so the core's stall-on-not-ready path is exercised in RTL.

## Interface

Parameters:
- `DEPTH`, 131072: RAM size in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states between acceptance and response; legal range 0..15.
- `ADDR_MASK`, 32'h7fff_ffff: applied to `I_addr` before decode.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `I_req`  input  1  transaction request; held by initiator until `O_ready`.
- `I_we`  input  1  1 = write, 0 = read.
- `I_addr`  input  32  byte address.
- `I_data`  input  32  write data.
- `I_mask`  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- `O_data`  output  32  read data; valid only in the `O_ready` cycle.
- `O_ready`  output  1  one-cycle completion pulse.
- `O_err`  output  1  asserted with `O_ready` when the address is out of range.

## Operation

- Effective address `ea = I_addr & ADDR_MASK`; word index `wi = ea[31:2]`; `ea[1:0]` ignored.
- In range iff `wi < DEPTH`.
- FSM states:
  - IDLE: when `I_req=1`, capture we/addr/data/mask into holding registers. Go to WAIT if `WAIT_CYCLES>0`, else RESP. Load the wait counter with `WAIT_CYCLES`.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to RESP.
  - RESP: drive `O_ready=1`. Unconditionally return to IDLE next cycle.
- Read: in RESP, `O_data = ram[wi]` from the captured address. Out-of-range reads return 32'h0 with `O_err=1`.
- Write: commits at the RESP clock edge. Only lanes with mask bit 1 are updated. Out-of-range writes are dropped with `O_err=1`. `O_data=0` for writes.
- `I_mask=4'b0000` write: completes normally and modifies nothing.
- Bus inputs are ignored outside IDLE. Changing or dropping `I_req` mid-transaction does not abort it; the captured transaction completes.
- Any `I_req=1` sampled in IDLE is a new transaction. The initiator must drop `I_req` in the cycle after `O_ready`, or present the next transaction then.

## Timing

- Request sampled in IDLE at edge N: `O_ready` is high during cycle N+1+`WAIT_CYCLES`.
  - Default `WAIT_CYCLES=1`: 2 cycles.
  - `WAIT_CYCLES=0`: 1 cycle.
- Back-to-back throughput: one transaction per `WAIT_CYCLES+2` cycles, because RESP always has one IDLE turnaround.
- Read-after-write to the same word: the read sees the new data, since the write committed at the earlier RESP edge.
- `O_ready`, `O_err` and `O_data` are registered outputs, with no combinational path from the bus inputs.
- Reset values: `O_ready=0`, `O_err=0`, `O_data=32'h0`, FSM=IDLE, wait counter=0, holding registers=0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no `O_ready` is issued. A pending write is discarded. RAM contents are preserved; RAM is not reset.
- The first request is accepted at the first rising edge after `rst` deasserts.

## Test plan

- Reset then read: `WAIT_CYCLES=1`, read addr 32'h8000_0010 from preloaded word 4 = 32'hdead_beef.
  - Required: `O_ready` high exactly 2 cycles after acceptance, `O_data=32'hdead_beef`, `O_err=0`.
- Byte-masked write:
  - Preload word 0 = 32'h1122_3344.
  - Write addr 32'h8000_0000, data 32'haabb_ccdd, mask 4'b0101.
  - Read back. Required: 32'h11bb_33dd.
- Out of range: `DEPTH=1024`, write to 32'h8000_1000 with mask 4'hf, then read the same address.
  - Both transactions: `O_ready=1`, `O_err=1`.
  - Read: `O_data=0`.
  - Word 0 is unchanged.
- Zero wait states and back-to-back: `WAIT_CYCLES=0`, 4 reads with `I_req` held high continuously.
  - Required: `O_ready` pulses every 2nd cycle, with data for each address in order.
- Mid-transaction abuse: `WAIT_CYCLES=3`.
  - Accept a write, then change `I_addr`/`I_data` and drop `I_req` during WAIT. Required: the original captured write commits at RESP.
  - Repeat, but pull `rst` low during WAIT. Required: no `O_ready`, the target word is unchanged, and all outputs are 0.
- Counter edge: `WAIT_CYCLES=15`, single read.
  - Required: `O_ready` exactly 16 cycles after acceptance, asserted for one cycle only.
